// File: rtl/seq_sum_pkg.sv
// Shared constants and helpers for the sequential-sum collector.
//   N_DEF, DW_DEF, DEPTH_DEF : default window log2, data width, FIFO depth
//   DROP_CNT_W               : width of the saturating drop counter
//   warm_len(n)              : warm-up length in clocks (2**n)
package seq_sum_pkg;

  localparam int unsigned N_DEF      = 4;
  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned DROP_CNT_W = 8;

  function automatic int unsigned warm_len(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/seq_sum_collector_if.sv
// Data/handshake bundle of the sequential-sum collector.
//   in_data   : upstream adder sum, sampled every clock
//   out_data  : FIFO head
//   out_valid : FIFO not empty
//   out_ready : consumer accepts head when out_valid is high
//   overflow  : sticky, a sample was dropped
//   drop_cnt  : saturating count of dropped samples
// master: the collector side; slave: the producer/consumer environment side.
interface seq_sum_collector_if
  import seq_sum_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
);

  logic [DW-1:0]         in_data;
  logic [DW-1:0]         out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_cnt;

  modport master (
    input  in_data,
    input  out_ready,
    output out_data,
    output out_valid,
    output overflow,
    output drop_cnt
  );

  modport slave (
    output in_data,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  overflow,
    input  drop_cnt
  );

endinterface

// File: rtl/seq_sum_fifo.sv
// Synchronous FIFO with a separate occupancy count.
//   clk, rst : clock, synchronous active-high reset (pointers/count only)
//   push     : write wdata (ignored when full unless a pop happens too)
//   pop      : advance the read pointer (ignored when empty)
//   wdata    : write data
//   rdata    : data at the head
//   full     : count == DEPTH
//   empty    : count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module seq_sum_fifo
  import seq_sum_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem[rptr_q];

  // A pop frees the slot this cycle, so a push into a full FIFO is fine then.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop_ok)  rptr_d = rptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/seq_sum_collector.sv
// Collects post-warm-up, decimated samples of an upstream windowed adder
// into a FIFO with a valid/ready output and drop accounting.
//   clk  : clock (rising edge)
//   rst  : synchronous active-high reset
//   bus  : seq_sum_collector_if.master (in_data, out_data, out_valid,
//          out_ready, overflow, drop_cnt)
// Build option: define SEQ_SUM_AVG_EN to store in_data >> N (window mean)
// instead of the raw sum.
module seq_sum_collector
  import seq_sum_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned DECIM = 1
) (
  input logic                 clk,
  input logic                 rst,
  seq_sum_collector_if.master bus
);

  localparam int unsigned WARM_LEN = warm_len(N);
  localparam int unsigned WW       = N + 1;

  logic [WW-1:0]         warm_q, warm_d;
  logic [7:0]            dec_q, dec_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  logic                  warm_done, cand, push, pop, drop;
  logic                  full, empty;
  logic [DW-1:0]         wdata;

  assign warm_done = (warm_q == WW'(WARM_LEN));
  assign cand      = warm_done && (dec_q == '0);
  assign pop       = bus.out_valid && bus.out_ready;
  assign push      = cand && (!full || pop);
  assign drop      = cand && full && !pop;

`ifdef SEQ_SUM_AVG_EN
  assign wdata = bus.in_data >> N;
`else
  assign wdata = bus.in_data;
`endif

  always_comb begin
    warm_d     = warm_q;
    dec_d      = dec_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    // Warm-up counter holds once it reaches the window length.
    if (!warm_done) warm_d = warm_q + 1'b1;
    // Decimation only starts counting once warm-up is over.
    if (warm_done) begin
      if (dec_q == 8'(DECIM - 1)) dec_d = '0;
      else                        dec_d = dec_q + 1'b1;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q     <= '0;
      dec_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      warm_q     <= warm_d;
      dec_q      <= dec_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  seq_sum_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (bus.out_data),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_valid = !empty;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_seq_sum_collector.sv
module tb_seq_sum_collector;
  import seq_sum_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_sum_collector_if #(.DW(DW)) bus_a ();
  seq_sum_collector_if #(.DW(DW)) bus_b ();

  seq_sum_collector #(
    .N     (N),
    .DW    (DW),
    .DEPTH (DEPTH),
    .DECIM (1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  seq_sum_collector #(
    .N     (N),
    .DW    (DW),
    .DEPTH (DEPTH),
    .DECIM (3)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] stored(input logic [DW-1:0] v);
`ifdef SEQ_SUM_AVG_EN
    return v >> N;
`else
    return v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    bus_a.in_data   = '0;
    bus_a.out_ready = 1'b0;
    bus_b.in_data   = 8'h40;
    bus_b.out_ready = 1'b1;
    tick();
    tick();
    check_eq("rst_valid", 32'(bus_a.out_valid), 32'd0);
    check_eq("rst_ovf", 32'(bus_a.overflow), 32'd0);
    check_eq("rst_drop", 32'(bus_a.drop_cnt), 32'd0);
    check_eq("rst_count", 32'(dut_a.u_fifo.count_q), 32'd0);
    rst = 1'b0;

    // Warm-up with out_ready high on an empty FIFO: no output, no underflow.
    bus_a.out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus_a.in_data = 8'(k);
      tick();
      check_eq("warm_valid", 32'(bus_a.out_valid), 32'd0);
    end
    check_eq("warm_count", 32'(dut_a.u_fifo.count_q), 32'd0);
    bus_a.in_data = 8'd16;
    tick();
    check_eq("first_valid", 32'(bus_a.out_valid), 32'd1);
    check_eq("first_data", 32'(bus_a.out_data), 32'(stored(8'd16)));

    // Streaming: output follows input one cycle later.
    for (int i = 0; i < 8; i++) begin
      bus_a.in_data = 8'(8'h20 + i);
      tick();
      check_eq("stream_data", 32'(bus_a.out_data), 32'(stored(8'(8'h20 + i))));
      check_eq("stream_count", 32'(dut_a.u_fifo.count_q), 32'd1);
    end
    check_eq("stream_drop", 32'(bus_a.drop_cnt), 32'd0);
    check_eq("stream_ovf", 32'(bus_a.overflow), 32'd0);

    // Overflow: 12 pushes into 8 slots with no consumer.
    bus_a.out_ready = 1'b0;
    do_reset();
    bus_a.in_data = '0;
    for (int k = 0; k < 16; k++) tick();
    for (int i = 0; i < 12; i++) begin
      bus_a.in_data = 8'(8'h50 + i);
      tick();
    end
    check_eq("ovf_count", 32'(dut_a.u_fifo.count_q), 32'd8);
    check_eq("ovf_flag", 32'(bus_a.overflow), 32'd1);
    check_eq("ovf_drop", 32'(bus_a.drop_cnt), 32'd4);
    check_eq("ovf_head", 32'(bus_a.out_data), 32'(stored(8'h50)));

    // Release: push and pop together on a full FIFO, order preserved.
    bus_a.out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      bus_a.in_data = 8'(8'h60 + i - 1);
      tick();
      check_eq("rel_data", 32'(bus_a.out_data), 32'(stored(8'(8'h50 + i))));
      check_eq("rel_count", 32'(dut_a.u_fifo.count_q), 32'd8);
      check_eq("rel_drop", 32'(bus_a.drop_cnt), 32'd4);
    end
    bus_a.in_data = 8'h67;
    tick();
    check_eq("rel_wrap", 32'(bus_a.out_data), 32'(stored(8'h60)));

    // Drop counter saturation.
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 300; i++) tick();
    check_eq("sat_drop", 32'(bus_a.drop_cnt), 32'd255);
    check_eq("sat_ovf", 32'(bus_a.overflow), 32'd1);

    // Mid-run reset with 5 entries held.
    do_reset();
    bus_a.in_data = '0;
    for (int k = 0; k < 16; k++) tick();
    for (int i = 0; i < 5; i++) begin
      bus_a.in_data = 8'(8'h70 + i);
      tick();
    end
    check_eq("mid_count", 32'(dut_a.u_fifo.count_q), 32'd5);
    rst = 1'b1;
    tick();
    check_eq("mid_valid", 32'(bus_a.out_valid), 32'd0);
    check_eq("mid_cnt0", 32'(dut_a.u_fifo.count_q), 32'd0);
    check_eq("mid_drop0", 32'(bus_a.drop_cnt), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      bus_a.in_data = 8'(8'h80 + k);
      tick();
      check_eq("mid_warm_a", 32'(bus_a.out_valid), 32'd0);
      check_eq("mid_warm_b", 32'(bus_b.out_valid), 32'd0);
    end
    bus_a.in_data = 8'h90;
    tick();
    check_eq("mid_first_v", 32'(bus_a.out_valid), 32'd1);
    check_eq("mid_first_d", 32'(bus_a.out_data), 32'(stored(8'h90)));

    // Decimation by 3 on dut_b with a constant 0x40 input and ready high.
    check_eq("dec_valid", 32'(bus_b.out_valid), 32'd1);
    check_eq("dec_data", 32'(bus_b.out_data), 32'(stored(8'h40)));
    for (int t = 1; t < 9; t++) begin
      tick();
      check_eq("dec_valid", 32'(bus_b.out_valid), (t % 3 == 0) ? 32'd1 : 32'd0);
      if (t % 3 == 0) check_eq("dec_data", 32'(bus_b.out_data), 32'(stored(8'h40)));
    end
    check_eq("dec_drop", 32'(bus_b.drop_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
